// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract engine.
package serial_addsub_pkg;

  // Engine control states; the fourth encoding is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_t;

  // Bit-counter width for a given operand width (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract engine: one full_adder cell plus a carry flop, LSB-first,
// valid/ready on both the operand and the result side.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic fa_sum;
  logic fa_co;

  // The single bit cell; operand LSBs and the running carry feed it every RUN cycle.
  full_adder u_full_adder (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .ci  (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // Next-state logic for the FSM, datapath shift registers and registered handshakes.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          a_sh_d     = a;
          b_sh_d     = b ^ {WIDTH{sub}};
          carry_d    = sub;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StRun;
        end
      end

      StRun: begin
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          // On the MSB, carry_q is the carry into the MSB and fa_co the carry out.
          co_d        = fa_co;
          ovf_d       = carry_q ^ fa_co;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  // State registers; reset discards any operation in flight and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: driver pushes expected results, monitor pops on handoff.
module tb_serial_addsub;

  localparam int unsigned W = 8;
  localparam int unsigned Lat = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    int unsigned  acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_out = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] rs, output logic rc, output logic ro);
    int          sx;
    int          sy;
    int          sr;
    int unsigned ur;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ur = int'(x) + ((1 << W) - int'(y));
      sr = sx - sy;
    end else begin
      ur = int'(x) + int'(y);
      sr = sx + sy;
    end
    rs = ur[W-1:0];
    rc = (ur >= (1 << W));
    ro = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                      input logic [W-1:0] es, input logic ec, input logic eo);
    bit acc;
    bit ok;
    exp_t e;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    sub      = ts;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (ok) begin
      e.sum     = es;
      e.co      = ec;
      e.ovf     = eo;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      n_acc++;
    end else begin
      check("accept_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Monitor: latency on first sight of out_valid, value compare on each handoff.
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          check("result_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) check("latency", cyc - sb_q[0].acc_cyc, Lat);
        end
        if (out_valid && out_ready) begin
          seen = 1'b0;
          n_out++;
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sum", sum, e.sum);
            check("co", co, e.co);
            check("ovf", ovf, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rx, ry, rs;
    logic         rsub, rc, ro;
    bit           got;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_co", co, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Directed add/sub corner cases.
    send(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    drain();

    // Backpressure with stray in_valid pulses in RUN and DONE.
    out_ready = 1'b0;
    send(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'hFF;
    sub      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("bp_reached_done", got, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 8'h8D);
      check("bp_co", co, 0);
      check("bp_ovf", ovf, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_handoff", out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    check("bp_no_extra", n_out, n_acc);

    // Asynchronous reset after three RUN edges.
    send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_sum", sum, 0);
    check("arst_co", co, 0);
    check("arst_ovf", ovf, 0);
    void'(sb_q.pop_back());
    n_acc--;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    drain();

    // Random back-to-back traffic against the reference model.
    for (int n = 0; n < 1000; n++) begin
      rx   = W'($urandom);
      ry   = W'($urandom);
      rsub = 1'($urandom_range(0, 1));
      model(rx, ry, rsub, rs, rc, ro);
      send(rx, ry, rsub, rs, rc, ro);
    end
    drain();
    check("result_count", n_out, n_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
